wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (the output of the MEM/WB stage, after MemtoReg selection) and a multi-cycle execution unit that returns results out of band.
- Holds a 2-entry result queue for the multi-cycle unit.
- Prevents that unit from starving by stalling the pipeline.
- Sits between the MEM/WB stage, the multi-cycle unit and the register file.

Parameters:
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- STARVE_MAX, 4, number of consecutive cycles a non-empty queue may lose arbitration before the queue is forced through

Ports:
- clk_i  in  1  clock, rising edge
- start_i  in  1  asynchronous active-low reset
- pipe_RegWrite_i  in  1  pipeline writeback request
- pipe_RDaddr_i  in  ADDR_W  pipeline destination register
- pipe_data_i  in  DATA_W  pipeline writeback data
- mc_valid_i  in  1  multi-cycle result valid
- mc_RDaddr_i  in  ADDR_W  multi-cycle destination register
- mc_data_i  in  DATA_W  multi-cycle result data
- mc_ready_o  out  1  multi-cycle result accepted this cycle when high with mc_valid_i
- stall_o  out  1  freeze the MEM/WB stage and everything upstream this cycle
- RegWrite_o  out  1  register-file write enable
- RDaddr_o  out  ADDR_W  register-file write address
- RDdata_o  out  DATA_W  register-file write data
- qcount_o  out  2  current queue occupancy, 0..2

Behaviour:
- Reset (start_i low, asynchronous):
  - queue empty; qcount_o=0; starvation counter=0.
  - mc_ready_o=0, stall_o=0, RegWrite_o=0, RDaddr_o=0, RDdata_o=0, all held while start_i is low.
- Write-port outputs and stall_o are combinational from the current inputs and registered state (zero latency to the register file).
- Queue, counter and qcount_o update on the rising edge of clk_i.
- pipe request is effective only if pipe_RegWrite_i=1 and pipe_RDaddr_i!=0.
- mc result with mc_RDaddr_i=0 is accepted when mc_ready_o=1 and discarded: no write, no enqueue.
- mc_ready_o=1 when qcount_o<2, or when the bypass condition below holds.
- Grant priority each cycle:
  1. Forced: queue non-empty and starve counter==STARVE_MAX. Write the queue head, pop it, stall_o=1. The pipe request is not written and must be re-presented next cycle, since MEM/WB holds.
  2. Pipe: effective pipe request. Write pipe data, stall_o=0.
  3. Queue: queue non-empty. Write head, pop.
  4. Bypass: queue empty and mc_valid_i with non-zero address. Write mc data directly, no enqueue.
  5. Otherwise RegWrite_o=0, RDaddr_o=0, RDdata_o=0.
- Enqueue: mc_valid_i && mc_ready_o && non-zero address && not bypassed. Entry goes to the tail.
- Simultaneous pop and push with qcount_o=2: mc_ready_o is still 0 (decided on pre-pop occupancy); no push.
- Squash on pipe win: any queued entry whose address equals pipe_RDaddr_i is invalidated and removed; the younger pipeline value wins.
  - If the head is squashed, the second entry becomes head.
  - An entry being enqueued that same cycle with a matching address is not squashed.
- Starve counter:
  - increments (saturating at STARVE_MAX) on a Pipe grant while the queue is non-empty.
  - clears on any pop, on a Forced grant, or whenever the queue is empty.
- qcount_o update: next = qcount − pops − squashes + push, clamped to 0..2 by construction.
- Reset mid-operation: queued results are lost and the starve counter clears. Upstream must re-issue.

Test Plan:
- Reset with mc_valid_i=1 held → all outputs 0, mc_ready_o=0; after start_i rises, qcount_o=0 and mc_ready_o=1.
- Queue empty, no pipe request; mc_valid_i=1, addr=7, data=0xDEAD → same cycle RegWrite_o=1, RDaddr_o=7, RDdata_o=0xDEAD, qcount_o stays 0.
- Pipe writes x3..x8 every cycle; mc pushes addr=9 then addr=10 → qcount_o=2, mc_ready_o=0; after STARVE_MAX(4) pipe wins, the next cycle has stall_o=1 and writes x9; the following cycle the pipe write resumes with the same address.
- Queue holds addr=5; pipe writes x5=0x11 → RDaddr_o=5, RDdata_o=0x11, entry squashed, qcount_o 1→0, x5 never rewritten.
- pipe_RegWrite_i=1 with pipe_RDaddr_i=0 and queue head addr=4 → queue head written to x4; mc result to x0 accepted and discarded.
- start_i pulsed low with qcount_o=2 → immediate qcount_o=0, RegWrite_o=0, no stale writes after release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle shared by the MEM/WB writeback,
// the multi-cycle result return and the register file.
interface wb_port_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              pipe_RegWrite_i;
  logic [ADDR_W-1:0] pipe_RDaddr_i;
  logic [DATA_W-1:0] pipe_data_i;
  logic              mc_valid_i;
  logic [ADDR_W-1:0] mc_RDaddr_i;
  logic [DATA_W-1:0] mc_data_i;
  logic              mc_ready_o;
  logic              stall_o;
  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic [1:0]        qcount_o;

  modport master (
    output pipe_RegWrite_i, pipe_RDaddr_i, pipe_data_i,
    output mc_valid_i, mc_RDaddr_i, mc_data_i,
    input  mc_ready_o, stall_o, RegWrite_o,
    input  RDaddr_o, RDdata_o, qcount_o
  );

  modport slave (
    input  pipe_RegWrite_i, pipe_RDaddr_i, pipe_data_i,
    input  mc_valid_i, mc_RDaddr_i, mc_data_i,
    output mc_ready_o, stall_o, RegWrite_o,
    output RDaddr_o, RDdata_o, qcount_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-port arbiter: pipeline writeback vs. multi-cycle results,
// with a 2-entry result queue and starvation-driven pipeline stall.
module wb_port_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic clk_i,
  input logic start_i,
  wb_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t          q0, q1, n0, n1, mcEnt;
  logic [1:0]    cnt, cntN;
  logic [SW-1:0] stv, stvN;

  logic pipeEff, mcNz, qNe, forced;
  logic pipeWin, qWin, bypass;
  logic ready, pop, push;
  logic keep0, keep1;

  always_comb begin
    pipeEff = bus.pipe_RegWrite_i &&
              (bus.pipe_RDaddr_i != '0);
    mcNz    = bus.mc_RDaddr_i != '0;
    qNe     = cnt != 2'd0;
    forced  = qNe && (stv == SW'(STARVE_MAX));
    pipeWin = !forced && pipeEff;
    qWin    = !forced && !pipeEff && qNe;
    bypass  = !qNe && !pipeEff &&
              bus.mc_valid_i && mcNz;
    // readiness uses pre-pop occupancy
    ready   = start_i && (cnt != 2'd2);
    pop     = forced || qWin;
    push    = bus.mc_valid_i && ready &&
              mcNz && !bypass;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      q0  <= '0;
      q1  <= '0;
      cnt <= '0;
      stv <= '0;
    end else begin
      q0  <= n0;
      q1  <= n1;
      cnt <= cntN;
      stv <= stvN;
    end
  end

  always_comb begin
    mcEnt.addr = bus.mc_RDaddr_i;
    mcEnt.data = bus.mc_data_i;
    // a pipe win squashes older queued writes to the same register
    keep0 = (cnt != 2'd0) && !pop &&
            !(pipeWin && q0.addr == bus.pipe_RDaddr_i);
    keep1 = (cnt == 2'd2) &&
            !(pipeWin && q1.addr == bus.pipe_RDaddr_i);
    n0 = q0;
    n1 = q1;
    if (keep0) begin
      n1 = keep1 ? q1 : mcEnt;
    end else if (keep1) begin
      n0 = q1;
      n1 = mcEnt;
    end else begin
      n0 = mcEnt;
    end
    cntN = 2'(keep0) + 2'(keep1) + 2'(push);
    stvN = stv;
    if (!qNe || pop)
      stvN = '0;
    else if (pipeWin && stv != SW'(STARVE_MAX))
      stvN = stv + SW'(1);
  end

  always_comb begin
    bus.RegWrite_o = 1'b0;
    bus.RDaddr_o   = '0;
    bus.RDdata_o   = '0;
    bus.stall_o    = 1'b0;
    if (start_i) begin
      unique case (1'b1)
        forced: begin
          bus.RegWrite_o = 1'b1;
          bus.RDaddr_o   = q0.addr;
          bus.RDdata_o   = q0.data;
          bus.stall_o    = 1'b1;
        end
        pipeWin: begin
          bus.RegWrite_o = 1'b1;
          bus.RDaddr_o   = bus.pipe_RDaddr_i;
          bus.RDdata_o   = bus.pipe_data_i;
        end
        qWin: begin
          bus.RegWrite_o = 1'b1;
          bus.RDaddr_o   = q0.addr;
          bus.RDdata_o   = q0.data;
        end
        bypass: begin
          bus.RegWrite_o = 1'b1;
          bus.RDaddr_o   = bus.mc_RDaddr_i;
          bus.RDdata_o   = bus.mc_data_i;
        end
        default: ;
      endcase
    end
  end

  assign bus.mc_ready_o = ready;
  assign bus.qcount_o   = cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with an expected-result queue.
// Each step drives one cycle of inputs and checks the combinational outputs.
module tb_wb_port_arbiter;
  logic clk_i;
  logic start_i;
  int   tests;
  int   fails;

  wb_port_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  wb_port_arbiter #(
    .ADDR_W(5), .DATA_W(32), .STARVE_MAX(4)
  ) dut (
    .clk_i  (clk_i),
    .start_i(start_i),
    .bus    (bus)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic        rdy;
    logic [1:0]  qc;
  } exp_t;

  exp_t sb[$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input string       tag,
    input logic        st,
    input logic        pw,
    input logic [4:0]  pa,
    input logic [31:0] pd,
    input logic        mv,
    input logic [4:0]  ma,
    input logic [31:0] md,
    input logic        ewe,
    input logic [4:0]  ea,
    input logic [31:0] ed,
    input logic        est,
    input logic        erdy,
    input logic [1:0]  eq
  );
    exp_t e;
    start_i             = st;
    bus.pipe_RegWrite_i = pw;
    bus.pipe_RDaddr_i   = pa;
    bus.pipe_data_i     = pd;
    bus.mc_valid_i      = mv;
    bus.mc_RDaddr_i     = ma;
    bus.mc_data_i       = md;
    sb.push_back('{we: ewe, addr: ea, data: ed,
                   stall: est, rdy: erdy, qc: eq});
    #2;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".we"},    32'(bus.RegWrite_o), 32'(e.we));
      chk({tag, ".addr"},  32'(bus.RDaddr_o),   32'(e.addr));
      chk({tag, ".data"},  bus.RDdata_o,        e.data);
      chk({tag, ".stall"}, 32'(bus.stall_o),    32'(e.stall));
      chk({tag, ".rdy"},   32'(bus.mc_ready_o), 32'(e.rdy));
      chk({tag, ".qc"},    32'(bus.qcount_o),   32'(e.qc));
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    start_i = 1'b0;
    bus.pipe_RegWrite_i = 1'b0;
    bus.pipe_RDaddr_i   = '0;
    bus.pipe_data_i     = '0;
    bus.mc_valid_i      = 1'b0;
    bus.mc_RDaddr_i     = '0;
    bus.mc_data_i       = '0;
    #1;

    // reset held with mc valid and a pipe request
    step("rst0", 0, 1, 5'd3, 32'h103, 1, 5'd3, 32'h33,
         0, 0, 0, 0, 0, 0);
    step("rst1", 0, 0, 0, 0, 1, 5'd3, 32'h33,
         0, 0, 0, 0, 0, 0);
    step("rel", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    // empty queue, no pipe: direct bypass
    step("byp", 1, 0, 0, 0, 1, 5'd7, 32'hDEAD,
         1, 5'd7, 32'hDEAD, 0, 1, 0);
    step("byp.idle", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    // starvation: pipe every cycle, two mc pushes
    step("sv1", 1, 1, 5'd3, 32'h103, 1, 5'd9, 32'h909,
         1, 5'd3, 32'h103, 0, 1, 0);
    step("sv2", 1, 1, 5'd4, 32'h104, 1, 5'd10, 32'hA0A,
         1, 5'd4, 32'h104, 0, 1, 1);
    step("sv3", 1, 1, 5'd5, 32'h105, 0, 0, 0,
         1, 5'd5, 32'h105, 0, 0, 2);
    step("sv4", 1, 1, 5'd6, 32'h106, 0, 0, 0,
         1, 5'd6, 32'h106, 0, 0, 2);
    step("sv5", 1, 1, 5'd7, 32'h107, 0, 0, 0,
         1, 5'd7, 32'h107, 0, 0, 2);
    step("sv.force", 1, 1, 5'd8, 32'h108, 1, 5'd11, 32'hB0B,
         1, 5'd9, 32'h909, 1, 0, 2);
    step("sv.resume", 1, 1, 5'd8, 32'h108, 0, 0, 0,
         1, 5'd8, 32'h108, 0, 1, 1);
    step("sv.drain", 1, 0, 0, 0, 0, 0, 0,
         1, 5'd10, 32'hA0A, 0, 1, 1);
    step("sv.empty", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    // squash: queued x5 overwritten by younger pipe write
    step("sq.enq", 1, 1, 5'd2, 32'h22, 1, 5'd5, 32'h55,
         1, 5'd2, 32'h22, 0, 1, 0);
    step("sq.win", 1, 1, 5'd5, 32'h11, 0, 0, 0,
         1, 5'd5, 32'h11, 0, 1, 1);
    step("sq.gone", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    // pipe write to x0 is ignored; mc result to x0 discarded
    step("x0.enq", 1, 1, 5'd2, 32'h2, 1, 5'd4, 32'h44,
         1, 5'd2, 32'h2, 0, 1, 0);
    step("x0.pipe", 1, 1, 5'd0, 32'hBAD, 1, 5'd0, 32'hEEE,
         1, 5'd4, 32'h44, 0, 1, 1);
    step("x0.after", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    // asynchronous reset with a full queue
    step("mr.enq1", 1, 1, 5'd3, 32'h103, 1, 5'd12, 32'hC,
         1, 5'd3, 32'h103, 0, 1, 0);
    step("mr.enq2", 1, 1, 5'd4, 32'h104, 1, 5'd13, 32'hD,
         1, 5'd4, 32'h104, 0, 1, 1);
    step("mr.full", 1, 0, 0, 0, 0, 0, 0,
         1, 5'd12, 32'hC, 0, 0, 2);
    step("mr.enq3", 1, 1, 5'd6, 32'h106, 1, 5'd14, 32'hE,
         1, 5'd6, 32'h106, 0, 1, 1);
    step("mr.rst", 0, 1, 5'd6, 32'h106, 1, 5'd14, 32'hE,
         0, 0, 0, 0, 0, 0);
    step("mr.rel", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);
    step("mr.idle", 1, 0, 0, 0, 0, 0, 0,
         0, 0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
